// File: rtl/bellek_hakemi.sv
// Arbitrates L1 instruction-cache (BB) and data-cache (VB) line transfers onto
// a single word-wide memory port, one outstanding word transaction at a time.
module bellek_hakemi #(
    parameter int SOZCUK_GENISLIGI    = 32,
    parameter int ADRES_GENISLIGI     = 32,
    parameter int SATIR_SOZCUK_SAYISI = 4,
    parameter int MASKE_GENISLIGI     = 4
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic                                          bb_istek_gecerli_i,
    input  logic [ADRES_GENISLIGI-1:0]                    bb_adres_i,
    output logic                                          bb_hazir_o,
    output logic                                          bb_yanit_gecerli_o,
    output logic [SATIR_SOZCUK_SAYISI*SOZCUK_GENISLIGI-1:0] bb_veri_o,
    input  logic                                          vb_istek_gecerli_i,
    input  logic                                          vb_yaz_i,
    input  logic [ADRES_GENISLIGI-1:0]                    vb_adres_i,
    input  logic [SATIR_SOZCUK_SAYISI*SOZCUK_GENISLIGI-1:0] vb_veri_i,
    output logic                                          vb_hazir_o,
    output logic                                          vb_yanit_gecerli_o,
    output logic [SATIR_SOZCUK_SAYISI*SOZCUK_GENISLIGI-1:0] vb_veri_o,
    output logic                                          bellek_istek_gecerli_o,
    output logic                                          bellek_yaz_o,
    output logic [ADRES_GENISLIGI-1:0]                    bellek_adres_o,
    output logic [SOZCUK_GENISLIGI-1:0]                   bellek_veri_o,
    output logic [MASKE_GENISLIGI-1:0]                    bellek_maske_o,
    input  logic                                          bellek_hazir_i,
    input  logic                                          bellek_yanit_gecerli_i,
    input  logic [SOZCUK_GENISLIGI-1:0]                   bellek_veri_i
);

    localparam int SATIR_GENISLIGI = SATIR_SOZCUK_SAYISI * SOZCUK_GENISLIGI;
    localparam int SAYAC_GENISLIGI = $clog2(SATIR_SOZCUK_SAYISI);
    localparam int OFSET           = SAYAC_GENISLIGI + 2;

    typedef enum logic [1:0] {BOS, ISTEK, BEKLE, YANIT} durum_t;

    durum_t                               durum;
    logic [SAYAC_GENISLIGI-1:0]           sayac;
    logic [SAYAC_GENISLIGI-1:0]           sayac_sonraki;
    logic [ADRES_GENISLIGI-OFSET-1:0]     satir;
    logic                                 yaz;
    logic                                 sahip_vb;
    logic                                 son_bb;
    logic                                 vb_secilir;
    logic [SATIR_GENISLIGI-1:0]           tampon;
    logic [SATIR_GENISLIGI-1:0]           tampon_yeni;

    // On a tie VB wins unless it was the last one served.
    always_comb begin
        sayac_sonraki = sayac + 1'b1;
        tampon_yeni   = tampon;
        tampon_yeni[sayac*SOZCUK_GENISLIGI +: SOZCUK_GENISLIGI] = bellek_veri_i;
        vb_secilir    = vb_istek_gecerli_i && (!bb_istek_gecerli_i || son_bb);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            durum                  <= BOS;
            sayac                  <= '0;
            satir                  <= '0;
            yaz                    <= 1'b0;
            sahip_vb               <= 1'b0;
            son_bb                 <= 1'b1;
            tampon                 <= '0;
            bb_hazir_o             <= 1'b0;
            bb_yanit_gecerli_o     <= 1'b0;
            bb_veri_o              <= '0;
            vb_hazir_o             <= 1'b0;
            vb_yanit_gecerli_o     <= 1'b0;
            vb_veri_o              <= '0;
            bellek_istek_gecerli_o <= 1'b0;
            bellek_yaz_o           <= 1'b0;
            bellek_adres_o         <= '0;
            bellek_veri_o          <= '0;
            bellek_maske_o         <= '0;
        end else begin
            bb_hazir_o         <= 1'b0;
            vb_hazir_o         <= 1'b0;
            bb_yanit_gecerli_o <= 1'b0;
            vb_yanit_gecerli_o <= 1'b0;
            case (durum)
                BOS: begin
                    sayac <= '0;
                    if (vb_secilir) begin
                        vb_hazir_o             <= 1'b1;
                        sahip_vb               <= 1'b1;
                        yaz                    <= vb_yaz_i;
                        satir                  <= vb_adres_i[ADRES_GENISLIGI-1:OFSET];
                        if (vb_yaz_i)
                            tampon <= vb_veri_i;
                        bellek_istek_gecerli_o <= 1'b1;
                        bellek_yaz_o           <= vb_yaz_i;
                        bellek_adres_o         <= {vb_adres_i[ADRES_GENISLIGI-1:OFSET], {OFSET{1'b0}}};
                        bellek_veri_o          <= vb_yaz_i ? vb_veri_i[SOZCUK_GENISLIGI-1:0] : '0;
                        bellek_maske_o         <= {MASKE_GENISLIGI{vb_yaz_i}};
                        durum                  <= ISTEK;
                    end else if (bb_istek_gecerli_i) begin
                        bb_hazir_o             <= 1'b1;
                        sahip_vb               <= 1'b0;
                        yaz                    <= 1'b0;
                        satir                  <= bb_adres_i[ADRES_GENISLIGI-1:OFSET];
                        bellek_istek_gecerli_o <= 1'b1;
                        bellek_yaz_o           <= 1'b0;
                        bellek_adres_o         <= {bb_adres_i[ADRES_GENISLIGI-1:OFSET], {OFSET{1'b0}}};
                        bellek_veri_o          <= '0;
                        bellek_maske_o         <= '0;
                        durum                  <= ISTEK;
                    end
                end
                ISTEK: begin
                    if (bellek_hazir_i) begin
                        bellek_istek_gecerli_o <= 1'b0;
                        bellek_yaz_o           <= 1'b0;
                        bellek_maske_o         <= '0;
                        durum                  <= BEKLE;
                    end
                end
                BEKLE: begin
                    if (bellek_yanit_gecerli_i) begin
                        if (!yaz)
                            tampon <= tampon_yeni;
                        // The last word goes straight to the owner's line output.
                        if (sayac == SAYAC_GENISLIGI'(SATIR_SOZCUK_SAYISI - 1)) begin
                            durum <= YANIT;
                            if (sahip_vb) begin
                                vb_yanit_gecerli_o <= 1'b1;
                                if (!yaz)
                                    vb_veri_o <= tampon_yeni;
                            end else begin
                                bb_yanit_gecerli_o <= 1'b1;
                                bb_veri_o          <= tampon_yeni;
                            end
                        end else begin
                            sayac                  <= sayac_sonraki;
                            bellek_istek_gecerli_o <= 1'b1;
                            bellek_yaz_o           <= yaz;
                            bellek_adres_o         <= {satir, sayac_sonraki, 2'b00};
                            bellek_veri_o          <= yaz ? tampon[sayac_sonraki*SOZCUK_GENISLIGI +: SOZCUK_GENISLIGI] : '0;
                            bellek_maske_o         <= {MASKE_GENISLIGI{yaz}};
                            durum                  <= ISTEK;
                        end
                    end
                end
                YANIT: begin
                    son_bb <= !sahip_vb;
                    durum  <= BOS;
                end
                default: durum <= BOS;
            endcase
        end
    end

endmodule
